// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
//
// Final pipeline stage. Accepts execute-stage result words into a 2-entry
// in-order FIFO, commits one word per cycle into a 32x32 register file,
// counts committed words and turns a committed taken branch into a
// one-cycle redirect/flush pulse that also drops anything still queued.
//
// Ports:
//   clock          - single clock, all state updates on the rising edge
//   reset          - synchronous, active-high; wins over every other event
//   ex_wb_valid    - an ex_wb word is offered this cycle
//   ex_wb[70:0]    - {we[70], branch[69], dest[68:64], pc[63:32], data[31:0]}
//   ex_wb_ready    - the block can accept a word this cycle
//   rs_addr/rt_addr- read port addresses
//   rs_data/rt_data- combinational read data, bypassing the commit in flight
//   redirect_valid - one-cycle pulse requesting a PC redirect
//   redirect_pc    - redirect target, held until the next branch commit
//   flush          - upstream squash, coincident with redirect_valid
//   retired_count  - number of committed words (wraps at 16 bits)
// ---------------------------------------------------------------------------
module writeback (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_wb_valid,
    input  logic [70:0] ex_wb,
    output logic        ex_wb_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] retired_count
);

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [70:0] fifo_q [2];
    logic [70:0] fifo_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] retired_q, retired_d;

    logic [70:0] head;
    logic        head_we;
    logic        head_br;
    logic [4:0]  head_dest;
    logic [31:0] head_pc;
    logic [31:0] head_data;
    logic        push;
    logic        commit;
    logic        wr_en;

    assign head      = fifo_q[rd_ptr_q];
    assign head_we   = head[70];
    assign head_br   = head[69];
    assign head_dest = head[68:64];
    assign head_pc   = head[63:32];
    assign head_data = head[31:0];

    assign ex_wb_ready = (count_q < 2'd2) && (state_q == RUN);
    assign push        = ex_wb_valid && ex_wb_ready;
    // The head commits every RUN cycle it exists; nothing ever stalls it.
    assign commit      = (state_q == RUN) && (count_q != 2'd0);
    assign wr_en       = commit && head_we && (head_dest != 5'd0);

    assign redirect_valid = (state_q == REDIRECT);
    assign flush          = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign retired_count  = retired_q;

    // Read ports forward the value being committed this cycle so a reader
    // never sees the stale register contents.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (wr_en && (head_dest == rs_addr)) begin
            rs_data = head_data;
        end
        if (wr_en && (head_dest == rt_addr)) begin
            rt_data = head_data;
        end
        if (rs_addr == 5'd0) begin
            rs_data = 32'd0;
        end
        if (rt_addr == 5'd0) begin
            rt_data = 32'd0;
        end
    end

    // FIFO bookkeeping. A REDIRECT cycle empties the queue outright; no push
    // can coincide with it because ready is low in that state.
    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ex_wb;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (commit) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, commit})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (state_q == REDIRECT) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    // Commit side effects: register write, retire count, branch redirect.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        retired_d     = retired_q;
        regs_d        = regs_q;
        if (wr_en) begin
            regs_d[head_dest] = head_data;
        end
        if (commit) begin
            retired_d = retired_q + 16'd1;
        end
        case (state_q)
            RUN: begin
                if (commit && head_br) begin
                    redirect_pc_d = head_pc;
                    state_d       = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            redirect_pc_q <= 32'd0;
            retired_q     <= 16'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            fifo_q        <= fifo_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            redirect_pc_q <= redirect_pc_d;
            retired_q     <= retired_d;
            regs_q        <= regs_d;
        end
    end

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback
//
// Self-checking bench for writeback: a table of single-word commits checked
// through a scoreboard queue, then hand-written sequences for branch
// redirect, back-to-back streaming, reset mid-operation and count wrap.
// ---------------------------------------------------------------------------
module tb_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_wb_valid;
    logic [70:0] ex_wb;
    logic        ex_wb_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] retired_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] value;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];

    writeback dut (
        .clock          (clock),
        .reset          (reset),
        .ex_wb_valid    (ex_wb_valid),
        .ex_wb          (ex_wb),
        .ex_wb_ready    (ex_wb_ready),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .retired_count  (retired_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clock = ~clock;

    function automatic logic [70:0] mk(input logic we, input logic br, input logic [4:0] dest,
                                       input logic [31:0] pc, input logic [31:0] data);
        return {we, br, dest, pc, data};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges, check the reset state, then release it.
    task automatic apply_reset;
        reset       = 1'b1;
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        tick();
        tick();
        check_output("rst_count", 32'(retired_count), 32'd0);
        check_output("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check_output("rst_flush", 32'(flush), 32'd0);
        check_output("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 1'b0;
        #1;
        check_output("ready_after_reset", 32'(ex_wb_ready), 32'd1);
    endtask

    // Offer one word for one cycle; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [70:0] word);
        ex_wb_valid = 1'b1;
        ex_wb       = word;
        #1;
        check_output("accept_ready", 32'(ex_wb_ready), 32'd1);
        tick();
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
    endtask

    initial begin
        exp_t        e;
        int          occ;
        int          idx;
        int          n;
        logic        acc;
        logic        cmt;
        logic [15:0] prev_cnt;
        logic [70:0] bp_words [3];
        logic [31:0] bp_data [3];

        reset       = 1'b1;
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        tbl[1] = '{1'b1, 5'd0,  32'h12345678, 32'h00000000, 16'd2};
        tbl[2] = '{1'b0, 5'd5,  32'h11111111, 32'hDEADBEEF, 16'd3};
        tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd4};
        tbl[4] = '{1'b1, 5'd5,  32'h00000001, 32'h00000001, 16'd5};
        tbl[5] = '{1'b1, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 16'd6};

        // Single-word commits, one at a time, checked via the scoreboard.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(mk(tbl[i].we, 1'b0, tbl[i].dest, 32'h0, tbl[i].data));
            sb.push_back('{tbl[i].dest, tbl[i].exp_rd, tbl[i].exp_cnt});
            rs_addr = tbl[i].dest;
            rt_addr = tbl[i].dest;
            #1;
            check_output($sformatf("bypass_rs_%0d", i), rs_data, tbl[i].exp_rd);
            tick();
            e = sb.pop_front();
            rs_addr = e.dest;
            rt_addr = e.dest;
            #1;
            check_output($sformatf("vec_rs_%0d", i), rs_data, e.value);
            check_output($sformatf("vec_rt_%0d", i), rt_data, e.value);
            check_output($sformatf("vec_cnt_%0d", i), 32'(retired_count), 32'(e.cnt));
        end

        // Branch commit followed by a word that must be flushed.
        apply_reset();
        apply_stimulus(mk(1'b1, 1'b1, 5'd3, 32'h00000040, 32'd7));
        ex_wb_valid = 1'b1;
        ex_wb       = mk(1'b1, 1'b0, 5'd4, 32'h0, 32'd9);
        #1;
        check_output("br_second_ready", 32'(ex_wb_ready), 32'd1);
        check_output("br_no_early_pulse", 32'(redirect_valid), 32'd0);
        tick();
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        rs_addr     = 5'd3;
        #1;
        check_output("br_redirect_valid", 32'(redirect_valid), 32'd1);
        check_output("br_flush", 32'(flush), 32'd1);
        check_output("br_redirect_pc", redirect_pc, 32'h00000040);
        check_output("br_ready_low", 32'(ex_wb_ready), 32'd0);
        check_output("br_count", 32'(retired_count), 32'd1);
        check_output("br_reg3", rs_data, 32'd7);
        tick();
        rs_addr = 5'd4;
        #1;
        check_output("br_pulse_end", 32'(redirect_valid), 32'd0);
        check_output("br_flush_end", 32'(flush), 32'd0);
        check_output("br_ready_back", 32'(ex_wb_ready), 32'd1);
        check_output("br_reg4", rs_data, 32'd0);
        check_output("br_pc_hold", redirect_pc, 32'h00000040);
        tick();
        check_output("br_count_final", 32'(retired_count), 32'd1);
        check_output("br_reg4_final", rs_data, 32'd0);

        // Three words offered back to back straight out of reset.
        bp_data[0]  = 32'h00000100;
        bp_data[1]  = 32'h00000200;
        bp_data[2]  = 32'h00000300;
        bp_words[0] = mk(1'b1, 1'b0, 5'd10, 32'h0, bp_data[0]);
        bp_words[1] = mk(1'b1, 1'b0, 5'd11, 32'h0, bp_data[1]);
        bp_words[2] = mk(1'b1, 1'b0, 5'd12, 32'h0, bp_data[2]);
        apply_reset();
        occ      = 0;
        idx      = 0;
        prev_cnt = 16'd0;
        n        = 0;
        while (((idx < 3) || (sb.size() != 0) || (occ != 0)) && (n < 20)) begin
            ex_wb_valid = (idx < 3);
            ex_wb       = (idx < 3) ? bp_words[idx] : '0;
            #1;
            check_output($sformatf("bp_ready_c%0d", n), 32'(ex_wb_ready), (occ < 2) ? 32'd1 : 32'd0);
            acc = ex_wb_valid && (occ < 2);
            cmt = (occ > 0);
            tick();
            n++;
            if (acc) begin
                sb.push_back('{bp_words[idx][68:64], bp_data[idx], 16'(prev_cnt + 16'd1 + 16'(sb.size()))});
                idx++;
            end
            occ = occ + (acc ? 1 : 0) - (cmt ? 1 : 0);
            if ((retired_count != prev_cnt) && (sb.size() != 0)) begin
                e = sb.pop_front();
                rs_addr = e.dest;
                #1;
                check_output($sformatf("bp_data_r%0d", e.dest), rs_data, e.value);
                check_output($sformatf("bp_cnt_r%0d", e.dest), 32'(retired_count), 32'(e.cnt));
                prev_cnt = retired_count;
            end
        end
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        check_output("bp_completed", 32'(n < 20), 32'd1);
        check_output("bp_count", 32'(retired_count), 32'd3);

        // Reset arriving while a branch sits at the FIFO head.
        apply_reset();
        apply_stimulus(mk(1'b1, 1'b0, 5'd5, 32'h0, 32'h0000BEEF));
        apply_stimulus(mk(1'b1, 1'b1, 5'd3, 32'h00000080, 32'd7));
        reset       = 1'b1;
        ex_wb_valid = 1'b1;
        ex_wb       = mk(1'b1, 1'b0, 5'd7, 32'h0, 32'd55);
        tick();
        check_output("mid_no_pulse", 32'(redirect_valid), 32'd0);
        check_output("mid_no_flush", 32'(flush), 32'd0);
        check_output("mid_count", 32'(retired_count), 32'd0);
        check_output("mid_redirect_pc", redirect_pc, 32'd0);
        for (int r = 0; r < 32; r++) begin
            rs_addr = 5'(r);
            #1;
            check_output($sformatf("mid_reg%0d", r), rs_data, 32'd0);
        end
        tick();
        reset       = 1'b0;
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        #1;
        check_output("mid_ready_after", 32'(ex_wb_ready), 32'd1);
        tick();
        rs_addr = 5'd7;
        rt_addr = 5'd3;
        #1;
        check_output("mid_ignored_word", rs_data, 32'd0);
        check_output("mid_branch_dropped", rt_data, 32'd0);
        check_output("mid_count_after", 32'(retired_count), 32'd0);
        check_output("mid_pulse_after", 32'(redirect_valid), 32'd0);

        // Stream no-write words until the count reaches its maximum, then wrap.
        apply_reset();
        ex_wb_valid = 1'b1;
        ex_wb       = mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        n = 0;
        while ((retired_count != 16'hFFFF) && (n < 70000)) begin
            tick();
            n++;
        end
        ex_wb_valid = 1'b0;
        ex_wb       = '0;
        check_output("wrap_preload", 32'(retired_count), 32'h0000FFFF);
        tick();
        check_output("wrap_zero", 32'(retired_count), 32'd0);
        tick();
        check_output("empty_no_count", 32'(retired_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
